// File: rtl/aoi22_exerciser_if.sv
// Pin and status bundle between the AOI22 exerciser and its environment.
// master: exerciser side (reads START/ZN, drives pins/status); slave: environment.
interface aoi22_exerciser_if #(
    parameter int ERRW = 5
);
    logic            START;
    logic            ZN;
    logic            A1;
    logic            A2;
    logic            B1;
    logic            B2;
    logic            BUSY;
    logic            DONE;
    logic            PASS;
    logic [ERRW-1:0] ERR_CNT;
    logic [3:0]      FAIL_VEC;

    modport master (
        input  START, ZN,
        output A1, A2, B1, B2, BUSY, DONE, PASS, ERR_CNT, FAIL_VEC
    );

    modport slave (
        output START, ZN,
        input  A1, A2, B1, B2, BUSY, DONE, PASS, ERR_CNT, FAIL_VEC
    );
endinterface

// File: rtl/aoi22_exerciser.sv
// Walks all 16 input vectors through an AOI22 cell, samples ZN after SETTLE
// cycles and reports pass/fail, a saturating error count and the first bad vector.
// Ports: CK clock, R async active-high reset, bus = exerciser side of the pin bundle.
module aoi22_exerciser #(
    parameter int SETTLE = 2,
    parameter int ERRW   = 5
) (
    input  logic                  CK,
    input  logic                  R,
    aoi22_exerciser_if.master     bus
);
    typedef enum logic [1:0] {
        IDLE,
        APPLY,
        CHECK,
        FIN
    } state_t;

    localparam logic [3:0] SETTLE_LAST = 4'(SETTLE - 1);

    state_t          state, state_nxt;
    logic [3:0]      vec, vec_nxt;
    logic [3:0]      cnt, cnt_nxt;
    logic [3:0]      pins, pins_nxt;
    logic [3:0]      fail_vec, fail_vec_nxt;
    logic [ERRW-1:0] err_cnt, err_cnt_nxt;
    logic            pass, pass_nxt;
    logic            seen, seen_nxt;
    logic            exp_zn;
    logic            miss;

    assign exp_zn = ~((vec[3] & vec[2]) | (vec[1] & vec[0]));
    assign miss   = (bus.ZN != exp_zn);

    always_ff @(posedge CK or posedge R) begin
        if (R) begin
            state    <= IDLE;
            vec      <= '0;
            cnt      <= '0;
            pins     <= '0;
            fail_vec <= '0;
            err_cnt  <= '0;
            pass     <= 1'b0;
            seen     <= 1'b0;
        end else begin
            state    <= state_nxt;
            vec      <= vec_nxt;
            cnt      <= cnt_nxt;
            pins     <= pins_nxt;
            fail_vec <= fail_vec_nxt;
            err_cnt  <= err_cnt_nxt;
            pass     <= pass_nxt;
            seen     <= seen_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        vec_nxt      = vec;
        cnt_nxt      = cnt;
        pins_nxt     = pins;
        fail_vec_nxt = fail_vec;
        err_cnt_nxt  = err_cnt;
        pass_nxt     = pass;
        seen_nxt     = seen;
        unique case (state)
            // The FIN cycle also accepts START so a held START restarts
            // immediately after DONE.
            IDLE, FIN: begin
                if (bus.START) begin
                    state_nxt    = APPLY;
                    vec_nxt      = '0;
                    cnt_nxt      = '0;
                    pins_nxt     = '0;
                    fail_vec_nxt = '0;
                    err_cnt_nxt  = '0;
                    pass_nxt     = 1'b0;
                    seen_nxt     = 1'b0;
                end else begin
                    state_nxt = IDLE;
                end
            end
            APPLY: begin
                if (cnt == SETTLE_LAST) begin
                    state_nxt = CHECK;
                end else begin
                    cnt_nxt = cnt + 4'd1;
                end
            end
            CHECK: begin
                if (miss) begin
                    if (err_cnt != '1) begin
                        err_cnt_nxt = err_cnt + 1'b1;
                    end
                    if (!seen) begin
                        seen_nxt     = 1'b1;
                        fail_vec_nxt = vec;
                    end
                end
                if (vec != 4'd15) begin
                    state_nxt = APPLY;
                    vec_nxt   = vec + 4'd1;
                    pins_nxt  = vec + 4'd1;
                    cnt_nxt   = '0;
                end else begin
                    state_nxt = FIN;
                    pins_nxt  = '0;
                    pass_nxt  = (err_cnt_nxt == '0);
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign bus.A1       = pins[3];
    assign bus.A2       = pins[2];
    assign bus.B1       = pins[1];
    assign bus.B2       = pins[0];
    assign bus.BUSY     = (state == APPLY) || (state == CHECK);
    assign bus.DONE     = (state == FIN);
    assign bus.PASS     = pass;
    assign bus.ERR_CNT  = err_cnt;
    assign bus.FAIL_VEC = fail_vec;
endmodule

// File: tb/tb_aoi22_exerciser.sv
// Directed bench for aoi22_exerciser: ideal, stuck-at and single-fault cell
// models, restart attempts, mid-run reset and a narrow saturating counter.
module tb_aoi22_exerciser;
    logic CK;
    logic R;
    int   mode;
    int   total;
    int   bad;

    aoi22_exerciser_if #(.ERRW(5)) bus ();
    aoi22_exerciser_if #(.ERRW(3)) bus_b ();

    aoi22_exerciser #(.SETTLE(2), .ERRW(5)) dut (
        .CK  (CK),
        .R   (R),
        .bus (bus.master)
    );

    aoi22_exerciser #(.SETTLE(2), .ERRW(3)) dut_b (
        .CK  (CK),
        .R   (R),
        .bus (bus_b.master)
    );

    initial CK = 1'b0;
    always #5 CK = ~CK;

    logic [3:0] pins;
    logic       ideal;
    assign pins  = {bus.A1, bus.A2, bus.B1, bus.B2};
    assign ideal = !((bus.A1 && bus.A2) || (bus.B1 && bus.B2));

    // Cell models: 0 ideal, 1 stuck-at-0, 2 stuck-at-1, 3 wrong only at 1010.
    always_comb begin
        case (mode)
            1:       bus.ZN = 1'b0;
            2:       bus.ZN = 1'b1;
            3:       bus.ZN = (pins == 4'd10) ? 1'b0 : ideal;
            default: bus.ZN = ideal;
        endcase
    end
    assign bus_b.ZN = 1'b0;

    task automatic step(input int n);
        repeat (n) @(posedge CK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic run(input int m, input bit restart, input bit with_b,
                       input bit exp_pass, input int exp_err,
                       input int exp_fv);
        mode        = m;
        bus.START   = 1'b1;
        bus_b.START = with_b;
        @(posedge CK);
        #1;
        bus.START   = 1'b0;
        bus_b.START = 1'b0;
        chk("busy_e0", 32'(bus.BUSY), 1);
        chk("pins_e0", 32'(pins), 0);
        chk("pass_clr", 32'(bus.PASS), 0);
        for (int k = 1; k < 16; k++) begin
            if (restart && k == 7) begin
                step(1);
                bus.START = 1'b1;
                step(1);
                bus.START = 1'b0;
                chk("restart_busy", 32'(bus.BUSY), 1);
                chk("restart_pins", 32'(pins), 6);
                step(1);
            end else begin
                step(2);
                chk("pins_hold", 32'(pins), 32'(k - 1));
                step(1);
            end
            chk("pins_walk", 32'(pins), 32'(k));
        end
        step(2);
        chk("done_early", 32'(bus.DONE), 0);
        step(1);
        chk("done", 32'(bus.DONE), 1);
        chk("busy_fin", 32'(bus.BUSY), 0);
        chk("pins_fin", 32'(pins), 0);
        chk("pass", 32'(bus.PASS), 32'(exp_pass));
        chk("err_cnt", 32'(bus.ERR_CNT), 32'(exp_err));
        chk("fail_vec", 32'(bus.FAIL_VEC), 32'(exp_fv));
        step(1);
        chk("done_pulse", 32'(bus.DONE), 0);
        chk("busy_idle", 32'(bus.BUSY), 0);
        chk("pass_hold", 32'(bus.PASS), 32'(exp_pass));
        chk("err_hold", 32'(bus.ERR_CNT), 32'(exp_err));
    endtask

    initial begin
        int done_seen;
        total       = 0;
        bad         = 0;
        mode        = 0;
        R           = 1'b1;
        bus.START   = 1'b0;
        bus_b.START = 1'b0;
        step(2);
        chk("rst_pins", 32'(pins), 0);
        chk("rst_busy", 32'(bus.BUSY), 0);
        chk("rst_done", 32'(bus.DONE), 0);
        chk("rst_pass", 32'(bus.PASS), 0);
        chk("rst_err", 32'(bus.ERR_CNT), 0);
        chk("rst_fv", 32'(bus.FAIL_VEC), 0);
        R = 1'b0;
        step(2);

        run(0, 1'b0, 1'b1, 1'b1, 0, 0);
        chk("b_err_sat", 32'(bus_b.ERR_CNT), 7);
        chk("b_pass", 32'(bus_b.PASS), 0);
        chk("b_fv", 32'(bus_b.FAIL_VEC), 0);
        step(2);
        run(1, 1'b0, 1'b0, 1'b0, 9, 0);
        step(2);
        run(2, 1'b1, 1'b0, 1'b0, 7, 3);
        step(2);
        run(3, 1'b0, 1'b0, 1'b0, 1, 10);
        step(2);
        run(0, 1'b0, 1'b0, 1'b1, 0, 0);
        step(2);

        mode      = 0;
        bus.START = 1'b1;
        @(posedge CK);
        #1;
        bus.START = 1'b0;
        step(24);
        chk("pre_rst_pins", 32'(pins), 8);
        chk("pre_rst_busy", 32'(bus.BUSY), 1);
        @(posedge CK);
        R = 1'b1;
        #1;
        chk("midrst_pins", 32'(pins), 0);
        chk("midrst_busy", 32'(bus.BUSY), 0);
        chk("midrst_done", 32'(bus.DONE), 0);
        chk("midrst_pass", 32'(bus.PASS), 0);
        chk("midrst_err", 32'(bus.ERR_CNT), 0);
        chk("midrst_fv", 32'(bus.FAIL_VEC), 0);
        step(2);
        R = 1'b0;
        done_seen = 0;
        for (int i = 0; i < 40; i++) begin
            step(1);
            if (bus.DONE || bus.BUSY) done_seen++;
        end
        chk("no_report", 32'(done_seen), 0);

        run(0, 1'b0, 1'b0, 1'b1, 0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
